// File: rtl/ysyx_22050710_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter and sequencer for the single pmem port.
// Define YSYX_22050710_ARB_RR_EN for round-robin; default is LSU-over-IFU priority.
module ysyx_22050710_mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ifu_req_valid,
    output logic                  o_ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_ifu_addr,
    output logic                  o_ifu_rvalid,
    output logic [DATA_WIDTH-1:0] o_ifu_rdata,
    input  logic                  i_lsu_req_valid,
    output logic                  o_lsu_req_ready,
    input  logic                  i_lsu_wen,
    input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
    input  logic [DATA_WIDTH-1:0] i_lsu_wdata,
    input  logic [7:0]            i_lsu_wmask,
    output logic                  o_lsu_rvalid,
    output logic [DATA_WIDTH-1:0] o_lsu_rdata,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_wen,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]            o_mem_wmask,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Clears the byte offset so memory always sees 8-byte aligned beats
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-3){1'b1}}, 3'b000};

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  gnt_ifu, gnt_lsu;

`ifdef YSYX_22050710_ARB_RR_EN
    logic                  last_owner_q, last_owner_d;
`endif

    // Grant decision: only in IDLE, purely from state and request valids
    always_comb begin
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        if (state_q == S_IDLE) begin
`ifdef YSYX_22050710_ARB_RR_EN
            if (i_ifu_req_valid && i_lsu_req_valid) begin
                gnt_lsu = (last_owner_q == OWN_IFU);
                gnt_ifu = (last_owner_q == OWN_LSU);
            end else begin
                gnt_lsu = i_lsu_req_valid;
                gnt_ifu = i_ifu_req_valid;
            end
`else
            gnt_lsu = i_lsu_req_valid;
            gnt_ifu = i_ifu_req_valid && !i_lsu_req_valid;
`endif
        end
    end

    // Next-state and request/response latching
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
`ifdef YSYX_22050710_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (gnt_lsu) begin
                    owner_d = OWN_LSU;
                    wen_d   = i_lsu_wen;
                    addr_d  = i_lsu_addr & ALIGN_MASK;
                    wdata_d = i_lsu_wdata;
                    wmask_d = i_lsu_wmask;
                    state_d = S_REQ;
`ifdef YSYX_22050710_ARB_RR_EN
                    last_owner_d = OWN_LSU;
`endif
                end else if (gnt_ifu) begin
                    owner_d = OWN_IFU;
                    wen_d   = 1'b0;
                    addr_d  = i_ifu_addr & ALIGN_MASK;
                    wdata_d = '0;
                    wmask_d = 8'h00;
                    state_d = S_REQ;
`ifdef YSYX_22050710_ARB_RR_EN
                    last_owner_d = OWN_IFU;
`endif
                end
            end
            S_REQ: begin
                if (i_mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    rdata_d = wen_q ? '0 : i_mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched-field registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IFU;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 8'h00;
            rdata_q <= '0;
`ifdef YSYX_22050710_ARB_RR_EN
            last_owner_q <= OWN_IFU;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
`ifdef YSYX_22050710_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign o_ifu_req_ready = gnt_ifu;
    assign o_lsu_req_ready = gnt_lsu;
    assign o_mem_req_valid = (state_q == S_REQ);
    assign o_mem_wen       = wen_q;
    assign o_mem_addr      = addr_q;
    assign o_mem_wdata     = wdata_q;
    assign o_mem_wmask     = wmask_q;
    assign o_ifu_rvalid    = (state_q == S_RESP) && (owner_q == OWN_IFU);
    assign o_lsu_rvalid    = (state_q == S_RESP) && (owner_q == OWN_LSU);
    assign o_ifu_rdata     = rdata_q;
    assign o_lsu_rdata     = rdata_q;

endmodule
